// File: rtl/celdas_pkg.sv
// celdas_pkg: shared FSM state type and default sizing for the serializer cells
package celdas_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/contador_bits.sv
// contador_bits: loadable down-counter with zero flag (bit index of the serializer)
module contador_bits #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = (cnt == '0);
endmodule

// File: rtl/serializador_l.sv
// serializador_l: parallel-to-serial converter, MSB first, with first/last bit flags
module serializador_l
  import celdas_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             l_out,
  output logic             l_valid,
  output logic             l_first,
  output logic             l_last,
  input  logic             l_ready,
  output logic             busy,
  output logic [CNT_W-1:0] words_done
);
  localparam int IW = idx_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0] idx;
  logic idx_zero, fire, take;
  assign fire = (state == IDLE) && din_valid;
  assign take = (state == SHIFT) && l_ready;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (din_valid ? SHIFT : IDLE) : ((l_ready && idx_zero) ? IDLE : SHIFT);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      words_done <= '0;
    end else begin
      state <= state_nx;
      if (fire) sr <= din;
      else if (take && !idx_zero) sr <= sr << 1;
      if (take && idx_zero) words_done <= words_done + 1'b1;
    end
  contador_bits #(.W(IW)) u_idx (
    .clk(clk),
    .rst(rst),
    .load(fire),
    .load_val(IW'(WIDTH - 1)),
    .dec(take && !idx_zero),
    .cnt(idx),
    .zero(idx_zero)
  );
  // l_out is masked outside SHIFT so leftover shift bits never leak onto the chain
  assign busy = (state == SHIFT);
  assign din_ready = (state == IDLE);
  assign l_valid = busy;
  assign l_out = busy & sr[WIDTH-1];
  assign l_first = busy && (idx == IW'(WIDTH - 1));
  assign l_last = busy && idx_zero;
endmodule

// File: tb/tb_serializador_l.sv
// tb_serializador_l: table, directed and random checks of serializador_l against a word/position model
module tb_serializador_l;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] din = '0;
  logic din_valid = 0, l_ready = 0;
  logic din_ready, l_out, l_valid, l_first, l_last, busy;
  logic [15:0] words_done;
  logic [0:0] s_din = '0;
  logic s_dv = 0, s_lr = 0;
  logic s_dr, s_lo, s_lv, s_lf, s_ll, s_busy;
  logic [1:0] s_wd;
  int tests = 0, fails = 0;
  bit m_busy = 0;
  logic [7:0] m_word = '0;
  int m_k = 0;
  logic [15:0] m_done = '0;

  always #5 clk = ~clk;

  serializador_l dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .l_out(l_out), .l_valid(l_valid), .l_first(l_first), .l_last(l_last),
    .l_ready(l_ready), .busy(busy), .words_done(words_done)
  );

  serializador_l #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .din(s_din), .din_valid(s_dv), .din_ready(s_dr),
    .l_out(s_lo), .l_valid(s_lv), .l_first(s_lf), .l_last(s_ll),
    .l_ready(s_lr), .busy(s_busy), .words_done(s_wd)
  );

  typedef struct {
    logic r;
    logic [7:0] d;
    logic v;
    logic lr;
    logic [21:0] exp;
  } vec_t;
  vec_t tbl[10];

  function automatic logic [21:0] dut_vec();
    return {din_ready, l_valid, l_out, l_first, l_last, busy, words_done};
  endfunction

  function automatic logic [21:0] model_vec();
    return {!m_busy, m_busy, m_busy & m_word[7 - m_k], m_busy && m_k == 0, m_busy && m_k == 7, m_busy, m_done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a word is "in flight" with m_k bits already delivered
  task automatic step(input logic r, input logic [7:0] d, input logic v, input logic lr);
    rst = r; din = d; din_valid = v; l_ready = lr;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_done = '0;
    end else if (!m_busy && v) begin
      m_busy = 1; m_word = d; m_k = 0;
    end else if (m_busy && lr) begin
      if (m_k == 7) begin
        m_busy = 0; m_done = m_done + 16'd1;
      end else m_k++;
    end
    @(negedge clk);
  endtask

  task automatic mstep(input string nm, input logic r, input logic [7:0] d, input logic v, input logic lr);
    step(r, d, v, lr);
    chk(nm, 32'(dut_vec()), 32'(model_vec()));
  endtask

  initial begin
    int n;
    logic [15:0] wd0;
    tbl[0] = '{1'b1, 8'h00, 1'b0, 1'b0, {6'b100000, 16'd0}};
    tbl[1] = '{1'b0, 8'hB2, 1'b1, 1'b1, {6'b011101, 16'd0}};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b010001, 16'd0}};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b011001, 16'd0}};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b011001, 16'd0}};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b010001, 16'd0}};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b010001, 16'd0}};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b011001, 16'd0}};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b010011, 16'd0}};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, {6'b100000, 16'd1}};
    @(negedge clk);
    step(1, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].lr);
      chk($sformatf("table[%0d]", i), 32'(dut_vec()), 32'(tbl[i].exp));
    end
    // stall three cycles on the fourth bit
    mstep("stall_accept", 0, 8'hB2, 1, 1);
    n = 0;
    for (int j = 1; j <= 40 && n == 0; j++) begin
      mstep("stall_seq", 0, 8'h5A, 1, !(j >= 4 && j <= 6));
      if (j >= 4 && j <= 6) chk("stall_hold", {l_valid, l_out, l_first, l_last}, 4'b1100);
      if (!busy) n = j;
    end
    chk("stall_len", n, 11);
    chk("stall_done", words_done, 16'd2);
    // back-to-back FF then 00
    mstep("b2b_accept", 0, 8'hFF, 1, 1);
    n = 0;
    for (int j = 1; j <= 40 && n == 0; j++) begin
      mstep("b2b_seq", 0, 8'h00, 1, 1);
      if (j == 8) chk("b2b_idle_gap", din_ready, 1'b1);
      if (j == 16) chk("b2b_last_bit", {l_valid, l_out, l_last}, 3'b101);
      if (j > 9 && !busy) n = j;
    end
    chk("b2b_len", n, 17);
    chk("b2b_done", words_done, 16'd4);
    // reset while the fifth bit is on the line
    mstep("rst_accept", 0, 8'hC3, 1, 1);
    for (int j = 0; j < 4; j++) mstep("rst_pre", 0, 8'h00, 0, 1);
    chk("rst_fifth_bit", {l_valid, l_out}, 2'b10);
    wd0 = m_done;
    mstep("rst_mid", 1, 8'hAA, 1, 1);
    chk("rst_mid_state", {l_valid, din_ready, words_done}, {2'b01, 16'd0});
    chk("rst_pre_count", wd0, 16'd4);
    mstep("rst_after_accept", 0, 8'h96, 1, 1);
    for (int j = 0; j < 8; j++) mstep("rst_after_seq", 0, 8'h00, 0, 1);
    chk("rst_after_done", words_done, 16'd1);
    // random traffic
    for (int j = 0; j < 400; j++)
      mstep("random", $urandom_range(0, 49) == 0, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    // WIDTH=1, CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      s_din = 1'b1; s_dv = 1; s_lr = 1;
      @(posedge clk); @(negedge clk);
      chk("w1_bit", {s_lv, s_lo, s_lf, s_ll, s_dr, s_busy}, 6'b111101);
      s_dv = 0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("w1_count[%0d]", i), {s_lv, s_wd}, {1'b0, 2'((i + 1) % 4)});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
